// File: rtl/tdc_pkg.sv
// ----------------------------------------------------------------------------
// tdc_pkg
// Shared constants and types for the TDC readout block.
//   TDC_STEPS   : number of taps in the TDC delay line (thermometer width)
//   CODE_W      : width of one decoded code (0..TDC_STEPS)
//   tdc_state_e : readout FSM state encoding
//   maj3        : 2-of-3 majority vote used for bubble correction
// ----------------------------------------------------------------------------
package tdc_pkg;

    localparam int TDC_STEPS = 48;
    localparam int CODE_W    = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_ACCUM   = 3'd4,
        ST_DONE    = 3'd5
    } tdc_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tdc_therm_decoder.sv
// ----------------------------------------------------------------------------
// tdc_therm_decoder
// Purely combinational thermometer-to-count decoder.  Each bit is replaced by
// the majority of itself and its two neighbours (removes single-bit bubbles),
// then the corrected word is popcounted.
//   i_therm : TDC_STEPS-bit thermometer word, bit 0 = first delay stage
//   o_code  : number of ones after bubble correction, 0..TDC_STEPS
// ----------------------------------------------------------------------------
module tdc_therm_decoder
    import tdc_pkg::*;
(
    input  logic [TDC_STEPS-1:0] i_therm,
    output logic [CODE_W-1:0]    o_code
);

    // Extended word: ext[i+1] = b[i]. Below bit 0 the line is treated as
    // already fired (1); above the last tap the last tap is replicated, so an
    // all-ones word decodes to TDC_STEPS and an all-zeros word to 0.
    logic [TDC_STEPS+1:0] ext;
    logic [TDC_STEPS-1:0] corr;

    assign ext = {i_therm[TDC_STEPS-1], i_therm, 1'b1};

    generate
        for (genvar gi = 0; gi < TDC_STEPS; gi++) begin : g_bubble
            assign corr[gi] = maj3(ext[gi], ext[gi+1], ext[gi+2]);
        end
    endgenerate

    always_comb begin
        o_code = '0;
        for (int i = 0; i < TDC_STEPS; i++) begin
            o_code = o_code + CODE_W'(corr[i]);
        end
    end

endmodule

// File: rtl/tdc_readout.sv
// ----------------------------------------------------------------------------
// tdc_readout
// Sequences N = 2^P_LOG2_SAMPLES TDC measurements, decodes each thermometer
// word after a 2-flop synchronizer, accumulates the codes and reports sum,
// truncated average and sticky over/underflow flags with a one-cycle valid.
// Each sample runs CLEAR -> CAPTURE -> SETTLE(2) -> ACCUM (5 cycles); a
// measurement ends with one DONE cycle.
//   i_Clk_Ref   : clock (shared with the TDC capture flops)
//   i_RST_n     : asynchronous active-low reset
//   i_TDC_raw   : thermometer word from the TDC
//   i_Start     : measurement request, only honoured in IDLE
//   o_TDC_RST_p : active-high clear to the TDC capture flops
//   o_Busy      : high whenever the FSM is not in IDLE
//   o_Valid     : one-cycle pulse, results below are fresh
//   o_Sum       : sum of the N decoded codes
//   o_Avg       : o_Sum >> P_LOG2_SAMPLES
//   o_Overflow  : some sample decoded to TDC_STEPS
//   o_Underflow : some sample decoded to 0
// P_LOG2_SAMPLES must lie in 0..6.
// ----------------------------------------------------------------------------
module tdc_readout
    import tdc_pkg::*;
#(
    parameter int P_LOG2_SAMPLES = 4
) (
    input  logic                             i_Clk_Ref,
    input  logic                             i_RST_n,
    input  logic [TDC_STEPS-1:0]             i_TDC_raw,
    input  logic                             i_Start,
    output logic                             o_TDC_RST_p,
    output logic                             o_Busy,
    output logic                             o_Valid,
    output logic [CODE_W+P_LOG2_SAMPLES-1:0] o_Sum,
    output logic [CODE_W-1:0]                o_Avg,
    output logic                             o_Overflow,
    output logic                             o_Underflow
);

    localparam int SUM_W = CODE_W + P_LOG2_SAMPLES;
    // Keep the sample counter at least one bit wide so N=1 still elaborates.
    localparam int CNT_W = (P_LOG2_SAMPLES == 0) ? 1 : P_LOG2_SAMPLES;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << P_LOG2_SAMPLES) - 1);

    // ------------------------------------------------------------------
    // Synchronizer for the TDC word (free running)
    // ------------------------------------------------------------------
    logic [TDC_STEPS-1:0] sync1_q;
    logic [TDC_STEPS-1:0] sync2_q;

    always_ff @(posedge i_Clk_Ref or negedge i_RST_n) begin
        if (!i_RST_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_TDC_raw;
            sync2_q <= sync1_q;
        end
    end

    logic [CODE_W-1:0] code;

    tdc_therm_decoder u_decoder (
        .i_therm (sync2_q),
        .o_code  (code)
    );

    // ------------------------------------------------------------------
    // Accumulation datapath (next values used in ACCUM)
    // ------------------------------------------------------------------
    tdc_state_e        state_q;
    logic              settle_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SUM_W-1:0]  acc_q;
    logic              ovf_q;
    logic              unf_q;

    logic [CNT_W-1:0]  cnt_d;
    logic [SUM_W-1:0]  acc_d;
    logic              ovf_d;
    logic              unf_d;
    logic [CODE_W-1:0] avg_d;

    assign cnt_d = cnt_q + CNT_W'(1);
    assign acc_d = acc_q + SUM_W'(code);
    assign ovf_d = ovf_q | (code == CODE_W'(TDC_STEPS));
    assign unf_d = unf_q | (code == '0);
    assign avg_d = CODE_W'(acc_d >> P_LOG2_SAMPLES);

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    logic              tdc_rst_q;
    logic              busy_q;
    logic              valid_q;
    logic [SUM_W-1:0]  sum_out_q;
    logic [CODE_W-1:0] avg_out_q;
    logic              ovf_out_q;
    logic              unf_out_q;

    always_ff @(posedge i_Clk_Ref or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q   <= ST_IDLE;
            settle_q  <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            tdc_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            sum_out_q <= '0;
            avg_out_q <= '0;
            ovf_out_q <= 1'b0;
            unf_out_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_Start) begin
                        state_q   <= ST_CLEAR;
                        tdc_rst_q <= 1'b1;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        acc_q     <= '0;
                        ovf_q     <= 1'b0;
                        unf_q     <= 1'b0;
                    end else begin
                        // Releases the TDC clear held since reset.
                        tdc_rst_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    tdc_rst_q <= 1'b0;
                    state_q   <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    settle_q <= 1'b0;
                    state_q  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    // Two cycles: the captured word reaches sync2_q at the end
                    // of the second one.
                    if (settle_q) begin
                        state_q <= ST_ACCUM;
                    end else begin
                        settle_q <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    acc_q <= acc_d;
                    ovf_q <= ovf_d;
                    unf_q <= unf_d;
                    cnt_q <= cnt_d;
                    if (cnt_q == LAST_SAMPLE) begin
                        state_q   <= ST_DONE;
                        valid_q   <= 1'b1;
                        sum_out_q <= acc_d;
                        avg_out_q <= avg_d;
                        ovf_out_q <= ovf_d;
                        unf_out_q <= unf_d;
                    end else begin
                        state_q   <= ST_CLEAR;
                        tdc_rst_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    tdc_rst_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_TDC_RST_p = tdc_rst_q;
    assign o_Busy      = busy_q;
    assign o_Valid     = valid_q;
    assign o_Sum       = sum_out_q;
    assign o_Avg       = avg_out_q;
    assign o_Overflow  = ovf_out_q;
    assign o_Underflow = unf_out_q;

endmodule

// File: doc/tdc_readout.md
TDC_READOUT -- requirements
Module: tdc_readout

Interface
REQ-001 Parameter P_LOG2_SAMPLES, default 4: number of samples averaged per measurement is N = 2^P_LOG2_SAMPLES, legal range 0..6.
REQ-002 i_Clk_Ref  in  1: single clock, shared with the 48-step TDC capture flops; one clock, all logic rising-edge.
REQ-003 i_RST_n  in  1: reset, asynchronous, active-low.
REQ-004 i_TDC_raw  in  48: thermometer word from the TDC, bit 0 = first delay stage.
REQ-005 i_Start  in  1: measurement request, sampled in IDLE only.
REQ-006 o_TDC_RST_p  out  1: active-high clear to the TDC capture flops.
REQ-007 o_Busy  out  1: high in every state except IDLE.
REQ-008 o_Valid  out  1: one-cycle pulse, results valid.
REQ-009 o_Sum  out  6+P_LOG2_SAMPLES: sum of N decoded codes.
REQ-010 o_Avg  out  6: o_Sum >> P_LOG2_SAMPLES (truncating).
REQ-011 o_Overflow  out  1: some sample decoded to 48 (edge beyond line).
REQ-012 o_Underflow  out  1: some sample decoded to 0.

Function
REQ-013 FSM states: IDLE, CLEAR, CAPTURE, SETTLE, ACCUM, DONE.
- IDLE -> CLEAR when i_Start=1; clears accumulator, sample counter, flags.
- CLEAR: o_TDC_RST_p=1 for exactly this cycle -> CAPTURE.
- CAPTURE: one cycle; TDC captures on the ending edge -> SETTLE.
- SETTLE: two cycles while i_TDC_raw passes a 2-flop synchronizer -> ACCUM.
- ACCUM: one cycle; adds decoded code to sum, updates flags, increments counter; counter==N-1 -> DONE, else -> CLEAR.
- DONE: o_Valid=1 one cycle -> IDLE.
REQ-014 Each sample takes 5 cycles; o_Valid asserts 5N+1 cycles after the cycle i_Start is sampled high in IDLE.
REQ-015 Decode: bubble-corrected word c[i] = majority(b[i-1], b[i], b[i+1]), with b[-1]=1 and b[48]=b[47]; code = popcount(c), range 0..48.
REQ-016 Decode is applied to the second synchronizer stage output only.
REQ-017 Sum width 6+P_LOG2_SAMPLES never wraps (max 48*N fits).
REQ-018 o_Sum, o_Avg, o_Overflow and o_Underflow update only in DONE; they hold until the next DONE.
REQ-019 Overflow and underflow are sticky across the N samples of one measurement and clear at the IDLE->CLEAR transition.
REQ-020 i_Start while o_Busy=1 is ignored; no queuing.
REQ-021 i_Start held high continuously starts a new measurement on the first IDLE cycle after each DONE.

Reset
REQ-022 On i_RST_n low: state = IDLE, o_TDC_RST_p = 1, synchronizer flops = 0, and all other outputs, sum and counter = 0.
REQ-023 o_TDC_RST_p stays 1 from reset until the first IDLE cycle with i_RST_n high.
REQ-024 Reset mid-measurement aborts it; no o_Valid is produced for the aborted measurement.

Structure
REQ-025 Package tdc_pkg holds TDC_STEPS=48, CODE_W=6, and the FSM state enum.
REQ-026 Sub-module tdc_therm_decoder: purely combinational bubble correction plus popcount, 48 in, 6 out.

Verification
REQ-027 N=16, raw = 20 ones at bits 0..19 -> o_Sum=320, o_Avg=20, both flags 0, o_Valid at cycle 81.
REQ-028 Bubble: ones at bits 0..19 except bit 10, plus bit 22 -> code 20 per sample, o_Avg=20.
REQ-029 raw all ones -> o_Avg=48, o_Overflow=1; next measurement with 20 ones -> o_Overflow=0.
REQ-030 raw all zeros in one sample, 30 ones in the others (N=16) -> o_Underflow=1, o_Sum=450, o_Avg=28.
REQ-031 i_Start pulsed during SETTLE -> ignored, exactly one o_Valid produced.
REQ-032 i_RST_n low during sample 7 -> outputs 0, o_TDC_RST_p=1; no o_Valid; a fresh i_Start completes normally.
